// File: rtl/gray_step_scheduler_if.sv
// Step-command handshake between two requesters (A, B) and the Gray step scheduler.
// Requesters drive valid/dir and hold both stable until the scheduler raises ready.
interface gray_step_scheduler_if;
  logic req_a_valid;
  logic req_a_dir;
  logic req_a_ready;
  logic req_b_valid;
  logic req_b_dir;
  logic req_b_ready;

  modport master (
    output req_a_valid, req_a_dir, req_b_valid, req_b_dir,
    input  req_a_ready, req_b_ready
  );

  modport slave (
    input  req_a_valid, req_a_dir, req_b_valid, req_b_dir,
    output req_a_ready, req_b_ready
  );
endinterface

// File: rtl/gray_step_scheduler.sv
// Shares one modulo-MODULUS up/down Gray counter between two requesters, with
// round-robin arbitration and a fixed settle gap after every step.
module gray_step_scheduler #(
  parameter int WIDTH         = 3,
  parameter int MODULUS       = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  gray_step_scheduler_if.slave cmd,
  output logic [WIDTH-1:0]     count,
  output logic [WIDTH-1:0]     code,
  output logic                 step_pulse,
  output logic                 wrap_pulse,
  output logic                 last_grant
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SETTLE = 1'b1;

  localparam int              SW          = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam logic [SW-1:0]   SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [WIDTH-1:0] COUNT_MAX  = WIDTH'(MODULUS - 1);
  localparam bit              HAS_SETTLE  = (SETTLE_CYCLES > 0);

  logic [0:0]       state;
  logic [SW-1:0]    settle_cnt;
  logic             grant;
  logic             grant_b;
  logic             step_up;
  logic             step_wrap;
  logic [WIDTH-1:0] next_count;

  // Grants depend only on valids, state, enable and last_grant, never on dir.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    grant   = 1'b0;
    grant_b = 1'b0;
    if (!reset && state == ST_IDLE && enable) begin
      if (cmd.req_a_valid && cmd.req_b_valid) begin
        grant   = 1'b1;
        grant_b = ~last_grant;
      end else if (cmd.req_a_valid) begin
        grant   = 1'b1;
      end else if (cmd.req_b_valid) begin
        grant   = 1'b1;
        grant_b = 1'b1;
      end
    end
  end

  assign cmd.req_a_ready = grant && !grant_b;
  assign cmd.req_b_ready = grant && grant_b;

  always_comb begin
    next_count = count;
    step_wrap  = 1'b0;
    step_up    = grant_b ? cmd.req_b_dir : cmd.req_a_dir;
    if (step_up) begin
      if (count == COUNT_MAX) begin
        next_count = '0;
        step_wrap  = 1'b1;
      end else begin
        next_count = count + 1'b1;
      end
    end else begin
      if (count == '0) begin
        next_count = COUNT_MAX;
        step_wrap  = 1'b1;
      end else begin
        next_count = count - 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      count      <= '0;
      code       <= '0;
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      step_pulse <= grant;
      wrap_pulse <= grant && step_wrap;
      if (grant) begin
        count      <= next_count;
        code       <= next_count ^ (next_count >> 1);
        last_grant <= grant_b;
      end
      case (state)
        ST_IDLE: begin
          if (grant && HAS_SETTLE) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
          end
        end
        default: begin
          // Enable is deliberately ignored here: the gap length is fixed.
          if (settle_cnt == SETTLE_LAST) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/gray_step_scheduler.md
Name: gray_step_scheduler

Overview:
- Single-clock controller that owns a modulo-MODULUS up/down Gray-code counter.
- Shares the counter between two requesters (A, B). Each requester issues step commands over a valid/ready handshake, with a direction bit per command.
- Arbitrates simultaneous requests round-robin, applies one step per accepted command, and enforces a settle gap between steps.
- Sits between the control logic and any Gray-coded position/sequence consumer.

Parameters:
- WIDTH, 3, bit width of the count and code outputs.
- MODULUS, 8, count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2^WIDTH.
- SETTLE_CYCLES, 2, idle cycles after each step before the next accept. 0 is legal.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = new commands may be accepted.
- req_a_valid  in  1  requester A has a command.
- req_a_dir  in  1  A direction: 1 = up, 0 = down.
- req_a_ready  out  1  A command is accepted this cycle.
- req_b_valid  in  1  requester B has a command.
- req_b_dir  in  1  B direction: 1 = up, 0 = down.
- req_b_ready  out  1  B command is accepted this cycle.
- count  out  WIDTH  registered binary count.
- code  out  WIDTH  registered Gray code, equal to count ^ (count >> 1).
- step_pulse  out  1  one-cycle pulse the cycle after each count update.
- wrap_pulse  out  1  one-cycle pulse, coincident with step_pulse, when the step wrapped.
- last_grant  out  1  requester of the most recent accept: 0 = A, 1 = B.

Behaviour:
- Reset (synchronous, active-high; clk and reset as named above):
  - count = 0, code = 0, step_pulse = 0, wrap_pulse = 0, last_grant = 1 (so A has first priority).
  - state = IDLE, settle counter = 0.
  - reset overrides everything, including mid-SETTLE. Any command presented in a reset cycle is not accepted.
- States: IDLE and SETTLE.
- IDLE:
  - If enable = 1 and at least one valid is high, grant exactly one requester:
    - only A valid -> A;
    - only B valid -> B;
    - both valid -> the requester that is not last_grant.
  - ready is combinational and high only for the granted requester, only in IDLE with enable = 1.
  - Accept means valid && ready in the same cycle. A valid that is not granted stays pending; the requester must hold valid and dir stable until ready.
  - On accept at edge t:
    - count updates using the granted dir; code updates to gray(new count); last_grant updates.
    - step_pulse = 1 in cycle t+1.
    - next state is SETTLE if SETTLE_CYCLES > 0, otherwise IDLE.
- Arithmetic:
  - up: count == MODULUS-1 -> 0 with wrap_pulse, else count+1.
  - down: count == 0 -> MODULUS-1 with wrap_pulse, else count-1.
  - code is always gray(count). Successive codes differ by exactly one bit, except at wrap when MODULUS is not a power of two; that exception is permitted.
- SETTLE:
  - Both readys are low.
  - The state is held for exactly SETTLE_CYCLES cycles, then returns to IDLE.
  - Minimum accept spacing is therefore 1 + SETTLE_CYCLES cycles. With SETTLE_CYCLES = 0, back-to-back accepts every cycle are legal.
- enable:
  - Low in IDLE: no accepts and no grant.
  - Dropping enable during SETTLE does not shorten or extend SETTLE.
- Pulses:
  - step_pulse and wrap_pulse are registered and high for exactly one cycle per accept.
  - With SETTLE_CYCLES = 0 and continuous accepts, step_pulse stays high continuously.
- Opposite-direction simultaneous requests never cancel each other. Each is a separate step, serialised by arbitration.
- No combinational path from dir to any output.

Test Plan:
- Reset then A up x8 (SETTLE_CYCLES = 2, enable = 1):
  - code = 001, 011, 010, 110, 111, 101, 100, 000;
  - accepts 3 cycles apart;
  - wrap_pulse only on the 8th step; step_pulse 8 times.
- From reset, B down x1: count = 7, code = 100, wrap_pulse = 1. Then B up x1: count = 0, code = 000, wrap_pulse = 1.
- A and B both valid continuously, A up and B down:
  - grants alternate A, B, A, B, starting with A;
  - count sequence 1, 0, 1, 0;
  - last_grant = 0, 1, 0, 1.
- A valid with enable = 0 for 5 cycles: req_a_ready = 0 and count unchanged. Raise enable: accept on that cycle, step_pulse the next cycle.
- Reset asserted in the 1st SETTLE cycle after an accept: next cycle count = 0, code = 000, state IDLE. A pending valid is accepted the cycle after reset deasserts.
- MODULUS = 5, SETTLE_CYCLES = 0, A up x6 back-to-back:
  - count = 1, 2, 3, 4, 0, 1 on consecutive cycles;
  - readys high every cycle;
  - wrap_pulse on the 5th step only.
